// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the bram_sp two-master arbiter.
// Optional statistics counters are enabled with BRAM_ARB_STATS_EN.
package bram_arb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 72;
    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned STAT_WIDTH_DEF = 16;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    typedef struct packed {
        logic                      wr;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
    } req_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. Grants are combinational on the valids and
// the last-granted port; the last-grant register advances on every grant.
module rr_arbiter2
    import bram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_valid_a,
    input  logic i_valid_b,
    output logic o_grant_a,
    output logic o_grant_b
);

    port_id_t r_last_grant;
    port_id_t w_pref;

    // Grant the sole requester, or the port that did not win last time.
    always_comb begin
        w_pref    = other_port(r_last_grant);
        o_grant_a = i_valid_a && (!i_valid_b || (w_pref == PORT_A));
        o_grant_b = i_valid_b && !o_grant_a;
    end

    // Remember the winner; reset to B so that A wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= PORT_B;
        end else if (o_grant_a) begin
            r_last_grant <= PORT_A;
        end else if (o_grant_b) begin
            r_last_grant <= PORT_B;
        end
    end

endmodule

// File: rtl/bram_sp_arbiter.sv
// Two-master valid/ready front end for a single-port block RAM (bram_sp).
// Round-robin grant drives the RAM port combinationally; read data returns
// one cycle later tagged to the granting master.
// Optional: define BRAM_ARB_STATS_EN for saturating grant/conflict counters.
module bram_sp_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
`ifdef BRAM_ARB_STATS_EN
   ,parameter int unsigned STAT_WIDTH = STAT_WIDTH_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_wr,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_wr,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef BRAM_ARB_STATS_EN
   ,output logic [STAT_WIDTH-1:0] stat_grants_a,
    output logic [STAT_WIDTH-1:0] stat_grants_b,
    output logic [STAT_WIDTH-1:0] stat_conflicts
`endif
);

    logic     w_grant_a;
    logic     w_grant_b;
    logic     r_rd_pend;
    port_id_t r_rd_tag;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid_a (a_req_valid),
        .i_valid_b (b_req_valid),
        .o_grant_a (w_grant_a),
        .o_grant_b (w_grant_b)
    );

    assign a_req_ready = w_grant_a;
    assign b_req_ready = w_grant_b;

    // RAM port mux: granted master drives it; idle defaults to A with write held off.
    always_comb begin
        ram_wr   = 1'b0;
        ram_addr = a_req_addr;
        ram_din  = a_req_wdata;
        if (w_grant_a) begin
            ram_wr = a_req_wr;
        end else if (w_grant_b) begin
            ram_wr   = b_req_wr;
            ram_addr = b_req_addr;
            ram_din  = b_req_wdata;
        end
    end

    // Pending-read tag: a granted read produces a one-cycle response next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= PORT_A;
        end else begin
            r_rd_pend <= (w_grant_a && !a_req_wr) || (w_grant_b && !b_req_wr);
            r_rd_tag  <= w_grant_b ? PORT_B : PORT_A;
        end
    end

    assign a_rsp_valid = r_rd_pend && (r_rd_tag == PORT_A);
    assign b_rsp_valid = r_rd_pend && (r_rd_tag == PORT_B);
    assign a_rsp_rdata = ram_dout;
    assign b_rsp_rdata = ram_dout;

`ifdef BRAM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_ga;
    logic [STAT_WIDTH-1:0] r_stat_gb;
    logic [STAT_WIDTH-1:0] r_stat_cf;

    // Saturating counters: per-port transfers and cycles with both valids high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_ga <= '0;
            r_stat_gb <= '0;
            r_stat_cf <= '0;
        end else begin
            if (w_grant_a && (r_stat_ga != '1)) r_stat_ga <= r_stat_ga + STAT_WIDTH'(1);
            if (w_grant_b && (r_stat_gb != '1)) r_stat_gb <= r_stat_gb + STAT_WIDTH'(1);
            if (a_req_valid && b_req_valid && (r_stat_cf != '1))
                r_stat_cf <= r_stat_cf + STAT_WIDTH'(1);
        end
    end

    assign stat_grants_a  = r_stat_ga;
    assign stat_grants_b  = r_stat_gb;
    assign stat_conflicts = r_stat_cf;
`endif

endmodule
